main_mem_arbiter: RTL and testbench

Shares the single-port main memory between three requesters: the core instruction port (ins), the core data port (dat) and the UART program loader (prg).
- prg owns memory exclusively while programming mode is active.
- Otherwise ins and dat are round-robin arbitrated.
- One transaction is outstanding at a time; the memory has a fixed read latency.
- Addresses outside the memory window get an error response without touching memory.

---
 rtl/main_mem_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_main_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_arbiter.sv
// Single-port main memory arbiter: prg exclusive in programming mode, otherwise ins/dat round-robin.
// Optional per-requester stall counters are enabled by defining ARB_STALL_CNT_EN.
module main_mem_arbiter #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h4000_0000,
    parameter int unsigned       MEM_WORDS = 32768,
    parameter int unsigned       MEM_LAT   = 1,
    localparam int unsigned      STRB_W    = DATA_W / 8,
    localparam int unsigned      MEM_AW    = $clog2(MEM_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prog_mode_i,

    input  logic              ins_valid_i,
    output logic              ins_ready_o,
    input  logic [ADDR_W-1:0] ins_addr_i,
    input  logic              ins_we_i,
    input  logic [DATA_W-1:0] ins_wdata_i,
    input  logic [STRB_W-1:0] ins_wstrb_i,
    output logic              ins_rvalid_o,
    output logic              ins_err_o,

    input  logic              dat_valid_i,
    output logic              dat_ready_o,
    input  logic [ADDR_W-1:0] dat_addr_i,
    input  logic              dat_we_i,
    input  logic [DATA_W-1:0] dat_wdata_i,
    input  logic [STRB_W-1:0] dat_wstrb_i,
    output logic              dat_rvalid_o,
    output logic              dat_err_o,

    input  logic              prg_valid_i,
    output logic              prg_ready_o,
    input  logic [ADDR_W-1:0] prg_addr_i,
    input  logic              prg_we_i,
    input  logic [DATA_W-1:0] prg_wdata_i,
    input  logic [STRB_W-1:0] prg_wstrb_i,
    output logic              prg_rvalid_o,
    output logic              prg_err_o,

    output logic [DATA_W-1:0] rsp_rdata_o,

`ifdef ARB_STALL_CNT_EN
    output logic [31:0]       ins_stall_cnt_o,
    output logic [31:0]       dat_stall_cnt_o,
    output logic [31:0]       prg_stall_cnt_o,
`endif

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [STRB_W-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {OWN_INS, OWN_DAT, OWN_PRG} owner_t;

    localparam int unsigned       CNT_W       = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [CNT_W-1:0]  LP_CNT_INIT = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam logic [ADDR_W:0]   LP_WIN      = (ADDR_W + 1)'(MEM_WORDS) << 2;
    localparam bit                LP_LAT1     = (MEM_LAT == 1);

    state_t              r_state;
    state_t              w_state_nxt;
    owner_t              r_owner;
    owner_t              w_win;
    logic                r_last_dat;
    logic                r_we;
    logic                r_err;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [STRB_W-1:0]   r_mem_wstrb;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_win_valid;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_we;
    logic [DATA_W-1:0]   w_wdata;
    logic [STRB_W-1:0]   w_wstrb;
    logic [ADDR_W-1:0]   w_off;
    logic                w_in_win;
    logic                w_accept;
    logic                w_capture;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_win       = OWN_INS;
        w_win_valid = 1'b0;
        if (prog_mode_i) begin
            w_win       = OWN_PRG;
            w_win_valid = prg_valid_i;
        end else if (ins_valid_i && dat_valid_i) begin
            w_win       = r_last_dat ? OWN_INS : OWN_DAT;
            w_win_valid = 1'b1;
        end else if (dat_valid_i) begin
            w_win       = OWN_DAT;
            w_win_valid = 1'b1;
        end else if (ins_valid_i) begin
            w_win       = OWN_INS;
            w_win_valid = 1'b1;
        end

        case (w_win)
            OWN_DAT: begin
                w_addr = dat_addr_i; w_we = dat_we_i; w_wdata = dat_wdata_i; w_wstrb = dat_wstrb_i;
            end
            OWN_PRG: begin
                w_addr = prg_addr_i; w_we = prg_we_i; w_wdata = prg_wdata_i; w_wstrb = prg_wstrb_i;
            end
            default: begin
                w_addr = ins_addr_i; w_we = ins_we_i; w_wdata = ins_wdata_i; w_wstrb = ins_wstrb_i;
            end
        endcase
    end

    // Unsigned window check; the low two offset bits are dropped so misaligned addresses are legal.
    assign w_off    = w_addr - MEM_BASE;
    assign w_in_win = (w_addr >= MEM_BASE) && ({1'b0, w_off} < LP_WIN);

    // Readies are held low while reset is asserted, not only after it is released.
    assign w_accept  = (r_state == ST_IDLE) && !rst_i && w_win_valid;
    assign w_capture = (r_state == ST_ACCESS && LP_LAT1) ||
                       (r_state == ST_WAIT && r_wait_cnt == '0);

    assign ins_ready_o = w_accept && (w_win == OWN_INS);
    assign dat_ready_o = w_accept && (w_win == OWN_DAT);
    assign prg_ready_o = w_accept && (w_win == OWN_PRG);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = w_in_win ? ST_ACCESS : ST_RESP;
            ST_ACCESS: w_state_nxt = LP_LAT1 ? ST_RESP : ST_WAIT;
            ST_WAIT:   if (r_wait_cnt == '0) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner     <= OWN_INS;
            r_last_dat  <= 1'b1;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_wait_cnt  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_win;
                r_we    <= w_we;
                r_err   <= !w_in_win;
                if (w_win != OWN_PRG) r_last_dat <= (w_win == OWN_DAT);
                if (w_in_win) begin
                    r_mem_addr  <= w_off[MEM_AW+1:2];
                    r_mem_wdata <= w_wdata;
                    r_mem_wstrb <= w_wstrb;
                end else begin
                    r_rdata <= '0;
                end
            end

            if (r_state == ST_ACCESS) begin
                r_wait_cnt <= LP_CNT_INIT;
            end else if (r_state == ST_WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end

            if (w_capture) r_rdata <= r_we ? '0 : mem_rdata_i;
        end
    end

    assign mem_req_o   = (r_state == ST_ACCESS);
    assign mem_we_o    = (r_state == ST_ACCESS) && r_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_wstrb_o = r_mem_wstrb;

    assign ins_rvalid_o = (r_state == ST_RESP) && (r_owner == OWN_INS);
    assign dat_rvalid_o = (r_state == ST_RESP) && (r_owner == OWN_DAT);
    assign prg_rvalid_o = (r_state == ST_RESP) && (r_owner == OWN_PRG);
    assign ins_err_o    = ins_rvalid_o && r_err;
    assign dat_err_o    = dat_rvalid_o && r_err;
    assign prg_err_o    = prg_rvalid_o && r_err;
    assign rsp_rdata_o  = r_rdata;

`ifdef ARB_STALL_CNT_EN
    logic [31:0] r_ins_stall;
    logic [31:0] r_dat_stall;
    logic [31:0] r_prg_stall;

    // Saturating counts of cycles a requester is valid but not granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ins_stall <= '0;
            r_dat_stall <= '0;
            r_prg_stall <= '0;
        end else begin
            if (ins_valid_i && !ins_ready_o && r_ins_stall != '1) r_ins_stall <= r_ins_stall + 32'd1;
            if (dat_valid_i && !dat_ready_o && r_dat_stall != '1) r_dat_stall <= r_dat_stall + 32'd1;
            if (prg_valid_i && !prg_ready_o && r_prg_stall != '1) r_prg_stall <= r_prg_stall + 32'd1;
        end
    end

    assign ins_stall_cnt_o = r_ins_stall;
    assign dat_stall_cnt_o = r_dat_stall;
    assign prg_stall_cnt_o = r_prg_stall;
`endif

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3, shared stimulus.
module tb_main_mem_arbiter;

    localparam int MEM_AW = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_mode;
    logic        ins_valid, dat_valid, prg_valid;
    logic [31:0] ins_addr, dat_addr, prg_addr;
    logic        ins_we, dat_we, prg_we;
    logic [31:0] ins_wdata, dat_wdata, prg_wdata;
    logic [3:0]  ins_wstrb, dat_wstrb, prg_wstrb;

    logic              ins_ready_1, dat_ready_1, prg_ready_1;
    logic              ins_rvalid_1, dat_rvalid_1, prg_rvalid_1;
    logic              ins_err_1, dat_err_1, prg_err_1;
    logic [31:0]       rsp_rdata_1, mem_wdata_1, mem_rdata_1;
    logic              mem_req_1, mem_we_1;
    logic [MEM_AW-1:0] mem_addr_1;
    logic [3:0]        mem_wstrb_1;

    logic              ins_ready_3, dat_ready_3, prg_ready_3;
    logic              ins_rvalid_3, dat_rvalid_3, prg_rvalid_3;
    logic              ins_err_3, dat_err_3, prg_err_3;
    logic [31:0]       rsp_rdata_3, mem_wdata_3, mem_rdata_3;
    logic              mem_req_3, mem_we_3;
    logic [MEM_AW-1:0] mem_addr_3;
    logic [3:0]        mem_wstrb_3;

`ifdef ARB_STALL_CNT_EN
    logic [31:0] ins_stall_1, dat_stall_1, prg_stall_1;
    logic [31:0] ins_stall_3, dat_stall_3, prg_stall_3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory contents: word 4 holds 0xDEADBEEF, every other word encodes its own index.
    function automatic logic [31:0] mem_word(input logic [MEM_AW-1:0] a);
        return (a == 15'd4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {17'd0, a});
    endfunction

    // Latency-1 memory: data valid in the request cycle.
    assign mem_rdata_1 = mem_req_1 ? mem_word(mem_addr_1) : 32'hBAD0_BAD0;

    // Latency-3 memory: data valid only two cycles after the request cycle.
    logic [1:0] lat_cnt = 2'd0;
    always @(posedge clk) begin
        if (mem_req_3)          lat_cnt <= 2'd1;
        else if (lat_cnt == 1)  lat_cnt <= 2'd2;
        else                    lat_cnt <= 2'd0;
    end
    assign mem_rdata_3 = (lat_cnt == 2'd2) ? mem_word(mem_addr_3) : 32'hBAD0_BAD0;

    main_mem_arbiter #(.MEM_LAT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .prog_mode_i(prog_mode),
        .ins_valid_i(ins_valid), .ins_ready_o(ins_ready_1), .ins_addr_i(ins_addr), .ins_we_i(ins_we),
        .ins_wdata_i(ins_wdata), .ins_wstrb_i(ins_wstrb), .ins_rvalid_o(ins_rvalid_1), .ins_err_o(ins_err_1),
        .dat_valid_i(dat_valid), .dat_ready_o(dat_ready_1), .dat_addr_i(dat_addr), .dat_we_i(dat_we),
        .dat_wdata_i(dat_wdata), .dat_wstrb_i(dat_wstrb), .dat_rvalid_o(dat_rvalid_1), .dat_err_o(dat_err_1),
        .prg_valid_i(prg_valid), .prg_ready_o(prg_ready_1), .prg_addr_i(prg_addr), .prg_we_i(prg_we),
        .prg_wdata_i(prg_wdata), .prg_wstrb_i(prg_wstrb), .prg_rvalid_o(prg_rvalid_1), .prg_err_o(prg_err_1),
        .rsp_rdata_o(rsp_rdata_1),
`ifdef ARB_STALL_CNT_EN
        .ins_stall_cnt_o(ins_stall_1), .dat_stall_cnt_o(dat_stall_1), .prg_stall_cnt_o(prg_stall_1),
`endif
        .mem_req_o(mem_req_1), .mem_we_o(mem_we_1), .mem_addr_o(mem_addr_1),
        .mem_wdata_o(mem_wdata_1), .mem_wstrb_o(mem_wstrb_1), .mem_rdata_i(mem_rdata_1)
    );

    main_mem_arbiter #(.MEM_LAT(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .prog_mode_i(prog_mode),
        .ins_valid_i(ins_valid), .ins_ready_o(ins_ready_3), .ins_addr_i(ins_addr), .ins_we_i(ins_we),
        .ins_wdata_i(ins_wdata), .ins_wstrb_i(ins_wstrb), .ins_rvalid_o(ins_rvalid_3), .ins_err_o(ins_err_3),
        .dat_valid_i(dat_valid), .dat_ready_o(dat_ready_3), .dat_addr_i(dat_addr), .dat_we_i(dat_we),
        .dat_wdata_i(dat_wdata), .dat_wstrb_i(dat_wstrb), .dat_rvalid_o(dat_rvalid_3), .dat_err_o(dat_err_3),
        .prg_valid_i(prg_valid), .prg_ready_o(prg_ready_3), .prg_addr_i(prg_addr), .prg_we_i(prg_we),
        .prg_wdata_i(prg_wdata), .prg_wstrb_i(prg_wstrb), .prg_rvalid_o(prg_rvalid_3), .prg_err_o(prg_err_3),
        .rsp_rdata_o(rsp_rdata_3),
`ifdef ARB_STALL_CNT_EN
        .ins_stall_cnt_o(ins_stall_3), .dat_stall_cnt_o(dat_stall_3), .prg_stall_cnt_o(prg_stall_3),
`endif
        .mem_req_o(mem_req_3), .mem_we_o(mem_we_3), .mem_addr_o(mem_addr_3),
        .mem_wdata_o(mem_wdata_3), .mem_wstrb_o(mem_wstrb_3), .mem_rdata_i(mem_rdata_3)
    );

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; prog_mode = 1'b0;
        ins_valid = 1'b1; dat_valid = 1'b0; prg_valid = 1'b0;
        ins_addr = 32'h4000_0010; dat_addr = '0; prg_addr = '0;
        ins_we = 1'b0; dat_we = 1'b0; prg_we = 1'b0;
        ins_wdata = '0; dat_wdata = '0; prg_wdata = '0;
        ins_wstrb = '0; dat_wstrb = '0; prg_wstrb = '0;
        idle(3);
        n_checks++; if (ins_ready_1 !== 1'b0) begin n_fail++; $display("FAIL reset_ins_ready got=%0b exp=0", ins_ready_1); end
        n_checks++; if ({mem_req_1, mem_we_1, ins_rvalid_1, dat_rvalid_1, prg_rvalid_1, ins_err_1, dat_err_1, prg_err_1} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl got=%b exp=00000000", {mem_req_1, mem_we_1, ins_rvalid_1, dat_rvalid_1, prg_rvalid_1, ins_err_1, dat_err_1, prg_err_1});
        end
        n_checks++; if ({mem_addr_1, mem_wdata_1, mem_wstrb_1, rsp_rdata_1} !== '0) begin
            n_fail++; $display("FAIL reset_data addr=%h wdata=%h wstrb=%h rdata=%h exp=0", mem_addr_1, mem_wdata_1, mem_wstrb_1, rsp_rdata_1);
        end
        ins_valid = 1'b0;
        rst = 1'b0;
    endtask

    // Both requesters valid from reset: grants alternate ins, dat with period 3.
    task automatic test_round_robin;
        @(negedge clk);
        ins_valid = 1'b1; ins_addr = 32'h4000_0020;
        dat_valid = 1'b1; dat_addr = 32'h4000_0040;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_checks++;
            if ({ins_ready_1, dat_ready_1} !== {c % 6 == 0, c % 6 == 3}) begin
                n_fail++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, {ins_ready_1, dat_ready_1}, {c % 6 == 0, c % 6 == 3});
            end
            n_checks++;
            if ({ins_rvalid_1, dat_rvalid_1} !== {c % 6 == 2, c % 6 == 5}) begin
                n_fail++; $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, {ins_rvalid_1, dat_rvalid_1}, {c % 6 == 2, c % 6 == 5});
            end
            if (c % 6 == 2) begin
                n_checks++; if (rsp_rdata_1 !== 32'hC0DE_0008) begin n_fail++; $display("FAIL rr_ins_rdata c=%0d got=%h exp=c0de0008", c, rsp_rdata_1); end
            end
            if (c % 6 == 5) begin
                n_checks++; if (rsp_rdata_1 !== 32'hC0DE_0010) begin n_fail++; $display("FAIL rr_dat_rdata c=%0d got=%h exp=c0de0010", c, rsp_rdata_1); end
            end
        end
        @(negedge clk);
        ins_valid = 1'b0; dat_valid = 1'b0;
        idle(8);
    endtask

    task automatic test_ins_read;
        ins_valid = 1'b1; ins_addr = 32'h4000_0010; ins_we = 1'b0; #1;
        n_checks++; if (ins_ready_1 !== 1'b1) begin n_fail++; $display("FAIL rd_ready got=%0b exp=1", ins_ready_1); end
        @(negedge clk); ins_valid = 1'b0; #1;
        n_checks++; if ({mem_req_1, mem_we_1, mem_addr_1} !== {1'b1, 1'b0, 15'd4}) begin
            n_fail++; $display("FAIL rd_mem req=%0b we=%0b addr=%h exp=1/0/0004", mem_req_1, mem_we_1, mem_addr_1);
        end
        @(negedge clk); #1;
        n_checks++; if ({ins_rvalid_1, ins_err_1, mem_req_1} !== 3'b100) begin
            n_fail++; $display("FAIL rd_rvalid got=%b exp=100", {ins_rvalid_1, ins_err_1, mem_req_1});
        end
        n_checks++; if (rsp_rdata_1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata got=%h exp=deadbeef", rsp_rdata_1); end
        @(negedge clk); #1;
        n_checks++; if (ins_rvalid_1 !== 1'b0) begin n_fail++; $display("FAIL rd_pulse got=%0b exp=0", ins_rvalid_1); end
        idle(6);
    endtask

    task automatic test_prog_write;
        prog_mode = 1'b1;
        ins_valid = 1'b1; ins_addr = 32'h4000_0020; ins_we = 1'b0;
        prg_valid = 1'b1; prg_addr = 32'h4000_0000; prg_we = 1'b1;
        prg_wdata = 32'h1234_5678; prg_wstrb = 4'b0011; #1;
        n_checks++; if ({prg_ready_1, ins_ready_1} !== 2'b10) begin n_fail++; $display("FAIL pw_ready got=%b exp=10", {prg_ready_1, ins_ready_1}); end
        @(negedge clk); prg_valid = 1'b0; #1;
        n_checks++; if ({mem_req_1, mem_we_1, mem_wstrb_1, mem_addr_1} !== {2'b11, 4'b0011, 15'd0}) begin
            n_fail++; $display("FAIL pw_mem req=%0b we=%0b wstrb=%b addr=%h exp=1/1/0011/0000", mem_req_1, mem_we_1, mem_wstrb_1, mem_addr_1);
        end
        n_checks++; if (mem_wdata_1 !== 32'h1234_5678) begin n_fail++; $display("FAIL pw_wdata got=%h exp=12345678", mem_wdata_1); end
        @(negedge clk); #1;
        n_checks++; if ({prg_rvalid_1, prg_err_1, ins_rvalid_1, ins_ready_1} !== 4'b1000) begin
            n_fail++; $display("FAIL pw_resp got=%b exp=1000", {prg_rvalid_1, prg_err_1, ins_rvalid_1, ins_ready_1});
        end
        n_checks++; if (rsp_rdata_1 !== 32'h0) begin n_fail++; $display("FAIL pw_rdata got=%h exp=00000000", rsp_rdata_1); end
        @(negedge clk); #1;
        n_checks++; if (ins_ready_1 !== 1'b0) begin n_fail++; $display("FAIL pw_ins_blocked got=%0b exp=0", ins_ready_1); end
        prog_mode = 1'b0; ins_valid = 1'b0; prg_we = 1'b0; prg_wstrb = '0;
        idle(8);
    endtask

    // Window boundaries and misalignment, issued from the dat port.
    task automatic test_window;
        logic [31:0]       t_addr [5] = '{32'h3FFF_FFFC, 32'h4000_0013, 32'h4001_FFFC, 32'h4002_0000, 32'hFFFF_FFFC};
        logic              t_err  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [MEM_AW-1:0] t_word [5] = '{15'd0, 15'd4, 15'h7FFF, 15'd0, 15'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dat_valid = 1'b1; dat_addr = t_addr[i]; dat_we = 1'b0; #1;
            n_checks++; if (dat_ready_1 !== 1'b1) begin n_fail++; $display("FAIL win%0d_ready got=%0b exp=1", i, dat_ready_1); end
            @(negedge clk); dat_valid = 1'b0; #1;
            n_checks++; if (mem_req_1 !== !t_err[i]) begin n_fail++; $display("FAIL win%0d_req got=%0b exp=%0b", i, mem_req_1, !t_err[i]); end
            if (t_err[i]) begin
                n_checks++; if ({dat_rvalid_1, dat_err_1, rsp_rdata_1} !== {2'b11, 32'h0}) begin
                    n_fail++; $display("FAIL win%0d_err rvalid=%0b err=%0b rdata=%h exp=1/1/00000000", i, dat_rvalid_1, dat_err_1, rsp_rdata_1);
                end
            end else begin
                n_checks++; if (mem_addr_1 !== t_word[i]) begin n_fail++; $display("FAIL win%0d_addr got=%h exp=%h", i, mem_addr_1, t_word[i]); end
                @(negedge clk); #1;
                n_checks++; if ({dat_rvalid_1, dat_err_1, rsp_rdata_1} !== {2'b10, mem_word(t_word[i])}) begin
                    n_fail++; $display("FAIL win%0d_resp rvalid=%0b err=%0b rdata=%h exp=1/0/%h", i, dat_rvalid_1, dat_err_1, rsp_rdata_1, mem_word(t_word[i]));
                end
            end
            @(negedge clk); #1;
            n_checks++; if (dat_rvalid_1 !== 1'b0) begin n_fail++; $display("FAIL win%0d_pulse got=%0b exp=0", i, dat_rvalid_1); end
            idle(6);
        end
    endtask

    task automatic test_lat3_read;
        @(negedge clk);
        ins_valid = 1'b1; ins_addr = 32'h4000_0010; ins_we = 1'b0; #1;
        n_checks++; if (ins_ready_3 !== 1'b1) begin n_fail++; $display("FAIL l3_ready got=%0b exp=1", ins_ready_3); end
        @(negedge clk); ins_valid = 1'b0; #1;
        n_checks++; if ({mem_req_3, mem_addr_3} !== {1'b1, 15'd4}) begin n_fail++; $display("FAIL l3_mem req=%0b addr=%h exp=1/0004", mem_req_3, mem_addr_3); end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk); #1;
            n_checks++; if ({ins_rvalid_3, mem_req_3} !== 2'b00) begin n_fail++; $display("FAIL l3_wait t+%0d got=%b exp=00", c, {ins_rvalid_3, mem_req_3}); end
        end
        @(negedge clk); #1;
        n_checks++; if ({ins_rvalid_3, ins_err_3, rsp_rdata_3} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL l3_resp rvalid=%0b err=%0b rdata=%h exp=1/0/deadbeef", ins_rvalid_3, ins_err_3, rsp_rdata_3);
        end
        idle(6);
    endtask

    // Reset asserted while the latency-3 instance sits in WAIT.
    task automatic test_reset_in_wait;
        int seen;
        @(negedge clk);
        ins_valid = 1'b1; ins_addr = 32'h4000_0020; #1;
        n_checks++; if (ins_ready_3 !== 1'b1) begin n_fail++; $display("FAIL rw_ready got=%0b exp=1", ins_ready_3); end
        @(negedge clk); ins_valid = 1'b0;
        @(negedge clk); rst = 1'b1; #1;
        n_checks++; if ({mem_req_3, mem_we_3, ins_rvalid_3, dat_rvalid_3, prg_rvalid_3, ins_err_3, dat_err_3, prg_err_3} !== 8'h00) begin
            n_fail++; $display("FAIL rw_ctrl got=%b exp=00000000", {mem_req_3, mem_we_3, ins_rvalid_3, dat_rvalid_3, prg_rvalid_3, ins_err_3, dat_err_3, prg_err_3});
        end
        n_checks++; if ({mem_addr_3, mem_wdata_3, mem_wstrb_3, rsp_rdata_3} !== '0) begin
            n_fail++; $display("FAIL rw_data addr=%h wdata=%h wstrb=%h rdata=%h exp=0", mem_addr_3, mem_wdata_3, mem_wstrb_3, rsp_rdata_3);
        end
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (ins_rvalid_3 || dat_rvalid_3 || prg_rvalid_3) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rw_no_resp got=%0d exp=0", seen); end
        ins_valid = 1'b1; dat_valid = 1'b1; dat_addr = 32'h4000_0040; #1;
        n_checks++; if ({ins_ready_3, dat_ready_3} !== 2'b10) begin n_fail++; $display("FAIL rw_first_grant got=%b exp=10", {ins_ready_3, dat_ready_3}); end
        @(negedge clk); ins_valid = 1'b0; dat_valid = 1'b0;
        idle(8);
    endtask

`ifdef ARB_STALL_CNT_EN
    task automatic test_stall_cnt;
        logic [31:0] before;
        @(negedge clk);
        prog_mode = 1'b1;
        before = dat_stall_1;
        dat_valid = 1'b1; dat_addr = 32'h4000_0040;
        idle(5);
        dat_valid = 1'b0; prog_mode = 1'b0; #1;
        n_checks++; if (dat_stall_1 - before !== 32'd5) begin n_fail++; $display("FAIL stall_dat got=%0d exp=5", dat_stall_1 - before); end
        idle(4);
    endtask
`endif

    initial begin
        test_reset;
        test_round_robin;
        test_ins_read;
        test_prog_write;
        test_window;
        test_lat3_read;
        test_reset_in_wait;
`ifdef ARB_STALL_CNT_EN
        test_stall_cnt;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
